// File: rtl/pwhash_uart_digest.sv
// Keyed CRC-32 digest engine behind a UART command port with RTS/CTS flow control.
// Commands: 0x01 + 4 secret bytes -> ack 0x01; 0x02 + N + N bytes -> 4-byte digest; other -> 0xEE.
`timescale 1ns/1ps
module pwhash_uart_digest #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic resetn,
    input  logic rx,
    input  logic cts,
    output logic tx,
    output logic rts
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]   POLY      = 32'hEDB88320;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    localparam logic [2:0] P_IDLE   = 3'd0;
    localparam logic [2:0] P_SECRET = 3'd1;
    localparam logic [2:0] P_LEN    = 3'd2;
    localparam logic [2:0] P_MSG    = 3'd3;
    localparam logic [2:0] P_ABSORB = 3'd4;
    localparam logic [2:0] P_RESP   = 3'd5;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic din);
        crc_step = {1'b0, crc[31:1]} ^ ((crc[0] ^ din) ? POLY : 32'h0000_0000);
    endfunction

    logic          rx_meta_r, rx_sync_r, rx_prev_r, cts_meta_r, cts_sync_r;
    logic [1:0]    rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shift_r;
    logic          rx_valid_r, rx_ferr_r;
    logic [0:0]    tx_state_r;
    logic [CW-1:0] tx_cnt_r;
    logic [8:0]    tx_frame_r;
    logic [3:0]    tx_left_r;
    logic          tx_r, rts_r;
    logic [2:0]    p_state_r;
    logic [1:0]    sec_cnt_r;
    logic [23:0]   sec_buf_r;
    logic [31:0]   secret_r, crc_r, resp_data_r;
    logic [7:0]    msg_left_r, crc_byte_r;
    logic [2:0]    crc_bits_r, resp_left_r;
    logic          tx_go_s;

    // A response byte leaves only when TX is idle and the host has signalled room.
    assign tx_go_s = (p_state_r == P_RESP) && (resp_left_r != 3'd0) &&
                     (tx_state_r == TX_IDLE) && cts_sync_r;
    assign tx  = tx_r;
    assign rts = rts_r;

    // Two-flop synchronizers for the asynchronous pins, plus rx history for edge detect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            cts_meta_r <= 1'b0;
            cts_sync_r <= 1'b0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            cts_meta_r <= cts;
            cts_sync_r <= cts_meta_r;
        end
    end

    // UART receiver: mid-bit sampling, glitch rejection on start, framing check on stop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
                    else                         rx_state_r <= RX_IDLE;
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                        else                  rx_bit_r   <= rx_bit_r + 3'd1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_IDLE;
                        rx_valid_r <= rx_sync_r;
                        rx_ferr_r  <= !rx_sync_r;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Command parser, bit-serial CRC and response sequencing; rts drops for the whole response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_state_r   <= P_IDLE;
            sec_cnt_r   <= 2'd0;
            sec_buf_r   <= 24'h000000;
            secret_r    <= 32'h0000_0000;
            crc_r       <= 32'hFFFF_FFFF;
            msg_left_r  <= 8'h00;
            crc_byte_r  <= 8'h00;
            crc_bits_r  <= 3'd0;
            resp_data_r <= 32'h0000_0000;
            resp_left_r <= 3'd0;
            rts_r       <= 1'b0;
        end else begin
            rts_r <= (p_state_r != P_RESP);
            case (p_state_r)
                P_IDLE: begin
                    if (rx_valid_r) begin
                        if (rx_shift_r == 8'h01) begin
                            sec_cnt_r <= 2'd0;
                            p_state_r <= P_SECRET;
                        end else if (rx_shift_r == 8'h02) begin
                            p_state_r <= P_LEN;
                        end else begin
                            resp_data_r <= 32'h0000_00EE;
                            resp_left_r <= 3'd1;
                            p_state_r   <= P_RESP;
                        end
                    end else begin
                        p_state_r <= P_IDLE;
                    end
                end
                P_SECRET: begin
                    if (rx_ferr_r) begin
                        p_state_r <= P_IDLE;
                    end else if (rx_valid_r) begin
                        if (sec_cnt_r == 2'd3) begin
                            secret_r    <= {rx_shift_r, sec_buf_r};
                            resp_data_r <= 32'h0000_0001;
                            resp_left_r <= 3'd1;
                            p_state_r   <= P_RESP;
                        end else begin
                            sec_buf_r <= {rx_shift_r, sec_buf_r[23:8]};
                            sec_cnt_r <= sec_cnt_r + 2'd1;
                        end
                    end else begin
                        p_state_r <= P_SECRET;
                    end
                end
                P_LEN: begin
                    if (rx_ferr_r) begin
                        p_state_r <= P_IDLE;
                    end else if (rx_valid_r) begin
                        crc_r <= ~secret_r;
                        if (rx_shift_r == 8'h00) begin
                            // Empty message: the digest collapses back to the secret itself.
                            resp_data_r <= secret_r;
                            resp_left_r <= 3'd4;
                            p_state_r   <= P_RESP;
                        end else begin
                            msg_left_r <= rx_shift_r;
                            p_state_r  <= P_MSG;
                        end
                    end else begin
                        p_state_r <= P_LEN;
                    end
                end
                P_MSG: begin
                    if (rx_ferr_r) begin
                        p_state_r <= P_IDLE;
                    end else if (rx_valid_r) begin
                        crc_byte_r <= rx_shift_r;
                        crc_bits_r <= 3'd7;
                        msg_left_r <= msg_left_r - 8'd1;
                        p_state_r  <= P_ABSORB;
                    end else begin
                        p_state_r <= P_MSG;
                    end
                end
                P_ABSORB: begin
                    crc_r      <= crc_step(crc_r, crc_byte_r[0]);
                    crc_byte_r <= {1'b0, crc_byte_r[7:1]};
                    if (crc_bits_r == 3'd0) begin
                        if (msg_left_r == 8'h00) begin
                            resp_data_r <= crc_step(crc_r, crc_byte_r[0]) ^ 32'hFFFF_FFFF;
                            resp_left_r <= 3'd4;
                            p_state_r   <= P_RESP;
                        end else begin
                            p_state_r <= P_MSG;
                        end
                    end else begin
                        crc_bits_r <= crc_bits_r - 3'd1;
                    end
                end
                P_RESP: begin
                    if (tx_go_s) begin
                        resp_data_r <= {8'h00, resp_data_r[31:8]};
                        resp_left_r <= resp_left_r - 3'd1;
                    end else if ((resp_left_r == 3'd0) && (tx_state_r == TX_IDLE)) begin
                        p_state_r <= P_IDLE;
                    end else begin
                        p_state_r <= P_RESP;
                    end
                end
                default: p_state_r <= P_IDLE;
            endcase
        end
    end

    // UART transmitter: start, 8 data bits LSB first, stop; each exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_frame_r <= 9'h1FF;
            tx_left_r  <= 4'd0;
            tx_r       <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= '0;
                    if (tx_go_s) begin
                        tx_r       <= 1'b0;
                        tx_frame_r <= {1'b1, resp_data_r[7:0]};
                        tx_left_r  <= 4'd9;
                        tx_state_r <= TX_SEND;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_left_r == 4'd0) begin
                            tx_r       <= 1'b1;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_r       <= tx_frame_r[0];
                            tx_frame_r <= {1'b1, tx_frame_r[8:1]};
                            tx_left_r  <= tx_left_r - 4'd1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                default: tx_state_r <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwhash_uart_digest.sv
// Directed bench for pwhash_uart_digest: command table plus flow-control, framing and reset sequences.
`timescale 1ns/1ps
module tb_pwhash_uart_digest;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic resetn, rx, cts;
    logic tx, rts;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] byte_q[$];
    logic       ok_q[$];
    logic       rts_q[$];

    typedef struct {
        string       name;
        int          n_cmd;
        logic [95:0] cmd;     // first byte sent lives in bits [7:0]
        int          n_resp;
        logic [31:0] resp;    // first byte expected lives in bits [7:0]
    } vec_t;
    vec_t vecs[10];

    pwhash_uart_digest #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .resetn(resetn), .rx(rx), .cts(cts), .tx(tx), .rts(rts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Decodes every tx frame, requiring each bit level to hold for exactly CPB cycles.
    initial begin : tx_monitor
        logic [9:0] fr;
        logic good, aborted, rs;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && tx === 1'b0) begin
                good = 1'b1; aborted = 1'b0; rs = rts; fr = '0;
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i > 0) @(negedge clk);
                    if (resetn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % CPB == 0) fr[i / CPB] = tx;
                    else if (fr[i / CPB] !== tx) good = 1'b0;
                end
                if (!aborted) begin
                    good = good && (fr[0] == 1'b0) && (fr[9] == 1'b1);
                    byte_q.push_back(fr[8:1]);
                    ok_q.push_back(good);
                    rts_q.push_back(rs);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_resp(input string name, input int n, input logic [31:0] exp);
        int waited;
        logic [7:0] b;
        logic g, r;
        waited = 0;
        while (byte_q.size() < n && waited < n * 12 * CPB + 400) begin
            @(negedge clk);
            waited++;
        end
        check({name, " count"}, 32'(byte_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (byte_q.size() > 0) begin
                b = byte_q.pop_front(); g = ok_q.pop_front(); r = rts_q.pop_front();
            end else begin
                b = 8'hxx; g = 1'b0; r = 1'bx;
            end
            check($sformatf("%s byte%0d", name, k), {24'h0, b}, {24'h0, exp[8*k +: 8]});
            check($sformatf("%s timing%0d", name, k), {31'h0, g}, 32'h1);
            check($sformatf("%s rts_busy%0d", name, k), {31'h0, r}, 32'h0);
        end
        waited = 0;
        while (rts !== 1'b1 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
        end
        check({name, " rts_release"}, {31'h0, rts}, 32'h1);
        repeat (2 * CPB) @(negedge clk);
        check({name, " no_extra"}, 32'(byte_q.size()), 32'h0);
    endtask

    task automatic run_cmd(input int n_cmd, input logic [95:0] cmd);
        for (int j = 0; j < n_cmd; j++) send_byte(cmd[8*j +: 8], 1'b1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lows, waited;
        vecs[0] = '{"hash_empty_s0",  2,  96'h02_00,                               4, 32'h0000_0000};
        vecs[0].cmd = 96'h00_02;
        vecs[1] = '{"bad_opcode",     1,  96'h7A,                                  1, 32'h0000_00EE};
        vecs[2] = '{"idle_after_ee",  2,  96'h00_02,                               4, 32'h0000_0000};
        vecs[3] = '{"load_ff",        5,  96'hFF_FF_FF_FF_01,                      1, 32'h0000_0001};
        vecs[4] = '{"hash_empty_ff",  2,  96'h00_02,                               4, 32'hFFFF_FFFF};
        vecs[5] = '{"load_12345678",  5,  96'h12_34_56_78_01,                      1, 32'h0000_0001};
        vecs[6] = '{"hash_empty_key", 2,  96'h00_02,                               4, 32'h1234_5678};
        vecs[7] = '{"load_zero",      5,  96'h00_00_00_00_01,                      1, 32'h0000_0001};
        vecs[8] = '{"hash_check_str", 11, 96'h39_38_37_36_35_34_33_32_31_09_02,   4, 32'hCBF4_3926};
        vecs[9] = '{"hash_one_zero",  3,  96'h00_01_02,                            4, 32'hD202_EF8D};

        rx = 1'b1; cts = 1'b1; resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", {31'h0, tx}, 32'h1);
        check("reset rts", {31'h0, rts}, 32'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle rts", {31'h0, rts}, 32'h1);

        for (int v = 0; v < 10; v++) begin
            run_cmd(vecs[v].n_cmd, vecs[v].cmd);
            expect_resp(vecs[v].name, vecs[v].n_resp, vecs[v].resp);
        end

        // Host not ready: the digest must wait, then drain intact once cts rises.
        cts = 1'b0;
        repeat (4) @(negedge clk);
        run_cmd(11, 96'h39_38_37_36_35_34_33_32_31_09_02);
        lows = 0;
        for (int i = 0; i < 30 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("cts_hold tx_idle", 32'(lows), 32'h0);
        check("cts_hold no_bytes", 32'(byte_q.size()), 32'h0);
        cts = 1'b1;
        expect_resp("cts_release", 4, 32'hCBF4_3926);

        // Framing error inside a secret load leaves the previous secret in place.
        run_cmd(5, 96'hDE_AD_BE_EF_01);
        expect_resp("load_deadbeef", 1, 32'h0000_0001);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (30 * CPB) @(negedge clk);
        check("frame_err no_resp", 32'(byte_q.size()), 32'h0);
        run_cmd(2, 96'h00_02);
        expect_resp("after_frame_err", 4, 32'hDEAD_BEEF);

        // Reset in the middle of a response byte.
        run_cmd(2, 96'h00_02);
        waited = 0;
        while (tx !== 1'b0 && waited < 40 * CPB) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reset resp_started", {31'h0, tx}, 32'h0);
        repeat (3 * CPB) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("mid_reset tx_async", {31'h0, tx}, 32'h1);
        check("mid_reset rts", {31'h0, rts}, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 30 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("mid_reset tx_quiet", 32'(lows), 32'h0);
        check("mid_reset no_bytes", 32'(byte_q.size()), 32'h0);
        run_cmd(2, 96'h00_02);
        expect_resp("after_reset", 4, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
